// File: rtl/pixel_stream_fifo_if.sv
// pixel_stream_fifo_if: pixel stream handshake and status bundle for pixel_stream_fifo.
interface pixel_stream_fifo_if #(parameter int COMP_W = 8, parameter int DEPTH = 8);
   logic                    in_valid;
   logic                    in_ready;
   logic [COMP_W-1:0]       in_r, in_g, in_b;
   logic [1:0]              mode;
   logic [COMP_W-1:0]       offset;
   logic                    out_valid;
   logic                    out_ready;
   logic [COMP_W-1:0]       out_r, out_g, out_b;
   logic [$clog2(DEPTH):0]  count;
   logic [7:0]              drop_cnt;
   modport master (
      output in_valid, in_r, in_g, in_b, mode, offset, out_ready,
      input  in_ready, out_valid, out_r, out_g, out_b, count, drop_cnt
   );
   modport slave (
      input  in_valid, in_r, in_g, in_b, mode, offset, out_ready,
      output in_ready, out_valid, out_r, out_g, out_b, count, drop_cnt
   );
endinterface

// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo: pixel FIFO that transforms each pixel on write and shows the head pixel combinationally.
module pixel_stream_fifo #(
   parameter int COMP_W = 8,
   parameter int DEPTH  = 8
) (
   input logic               clk,
   input logic               rst_n,
   pixel_stream_fifo_if.slave px
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [3*COMP_W-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic [7:0]          drop_cnt;
   logic                wr, rd;
   logic [COMP_W+1:0]   y;
   logic [COMP_W:0]     sr, sg, sb;
   logic [3*COMP_W-1:0] pix;
   always_comb begin
      y   = ({2'b0, px.in_r} + {1'b0, px.in_g, 1'b0} + {2'b0, px.in_b}) >> 2;
      sr  = {1'b0, px.in_r} + {1'b0, px.offset};
      sg  = {1'b0, px.in_g} + {1'b0, px.offset};
      sb  = {1'b0, px.in_b} + {1'b0, px.offset};
      pix = px.mode == 2'b00 ? {px.in_r, px.in_g, px.in_b} :
            px.mode == 2'b01 ? {px.in_b, px.in_g, px.in_r} :
            px.mode == 2'b10 ? {3{y[COMP_W-1:0]}} :
            {sr[COMP_W] ? {COMP_W{1'b1}} : sr[COMP_W-1:0],
             sg[COMP_W] ? {COMP_W{1'b1}} : sg[COMP_W-1:0],
             sb[COMP_W] ? {COMP_W{1'b1}} : sb[COMP_W-1:0]};
   end
   // in_ready is gated by rst_n so it drops asynchronously with the reset
   assign px.in_ready  = rst_n && (count != FULL);
   assign px.out_valid = count != '0;
   assign {px.out_r, px.out_g, px.out_b} = px.out_valid ? mem[rd_ptr] : '0;
   assign px.count     = count;
   assign px.drop_cnt  = drop_cnt;
   assign wr = px.in_valid && px.in_ready;
   assign rd = px.out_valid && px.out_ready;
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= pix;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
         if (px.in_valid && !px.in_ready && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
      end
endmodule

// File: doc/pixel_stream_fifo.md
PIXEL_STREAM_FIFO -- requirements
Module: pixel_stream_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are listed first.
REQ-002 Parameter COMP_W SHALL default to 8 and set the width of each colour component R, G and B.
REQ-003 Parameter DEPTH SHALL default to 8, is a power of 2 and at least 2, and sets the number of stored pixels.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  input pixel present.
REQ-007 in_ready  out  1  block can accept an input pixel.
REQ-008 in_r, in_g, in_b  in  COMP_W each  input components.
REQ-009 mode  in  2  transform selected for the pixel being accepted: 00 pass, 01 swap, 10 gray, 11 offset.
REQ-010 offset  in  COMP_W  brightness offset used in mode 11.
REQ-011 out_valid  out  1  head pixel available.
REQ-012 out_ready  in  1  downstream accepts the head pixel.
REQ-013 out_r, out_g, out_b  out  COMP_W each  head pixel components.
REQ-014 count  out  $clog2(DEPTH)+1  number of stored pixels.
REQ-015 drop_cnt  out  8  saturating count of cycles with in_valid=1 and in_ready=0.

Function
REQ-016 A write SHALL occur on a rising edge when in_valid=1 and in_ready=1.
REQ-017 A read SHALL occur on a rising edge when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL equal (count<DEPTH) while rst_n=1.
REQ-019 When full, a write SHALL NOT occur, even if a read happens in the same cycle.
REQ-020 out_valid SHALL equal (count!=0); out_r, out_g and out_b SHALL show the head entry combinationally and SHALL be 0 when empty.
REQ-021 The transform SHALL be applied at write time using the mode and offset values present in the accepting cycle, and the transformed pixel SHALL be stored.
REQ-022 Mode 00 SHALL store (R,G,B) unchanged.
REQ-023 Mode 01 SHALL store (B,G,R).
REQ-024 Mode 10 SHALL compute Y=(R+2G+B)>>2 in COMP_W+2 bits, truncate Y to COMP_W bits, and store it to all three components.
REQ-025 Mode 11 SHALL store each component as min(comp+offset, 2^COMP_W-1), with the sum computed in COMP_W+1 bits.
REQ-026 Latency SHALL be 1 cycle: a pixel written into an empty FIFO at edge k is presented with out_valid=1 immediately after edge k.
REQ-027 Order SHALL be strict FIFO; write and read pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-028 A simultaneous write and read SHALL leave count unchanged; write alone SHALL add 1 to count; read alone SHALL subtract 1 from count.
REQ-029 A simultaneous write and read on an empty FIFO SHALL NOT occur, because out_valid=0 blocks the read; only the write takes effect.
REQ-030 drop_cnt SHALL increment on each cycle with in_valid=1 and in_ready=0, and SHALL hold at 255.
REQ-031 A read SHALL NOT increment drop_cnt.
REQ-032 Storage contents SHALL NOT be observable except through the head entry.

Reset
REQ-033 While rst_n=0, asynchronously: pointers=0, count=0, drop_cnt=0, out_valid=0, out_r/g/b=0, in_ready=0.
REQ-034 Storage memory SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard all stored pixels.
REQ-036 in_ready SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-037 Mode 00 with (25,55,98) written into an empty FIFO SHALL give out_valid=1 with out=(25,55,98) after 1 edge, and count=1.
REQ-038 Mode 01 with (45,75,95) SHALL give out=(95,75,45); mode 10 with (40,80,120) SHALL give out=(80,80,80).
REQ-039 Mode 11 with offset=200 and input (100,30,0) SHALL give out=(255,230,200).
REQ-040 Writing 8 pixels with out_ready=0 and then holding in_valid=1 for 3 more cycles SHALL give count=8, in_ready=0 and drop_cnt=3; draining SHALL return the 8 pixels in order.
REQ-041 At full, with in_valid=1 and out_ready=1 together, SHALL produce a read only on the first edge (count 8->7); the next edge SHALL produce a write and a read together (count 7->7), and pointers SHALL wrap correctly over 20 streamed pixels.
REQ-042 Asserting rst_n=0 with count=5 SHALL force count=0 and out_valid=0 immediately, without waiting for a clock edge; after release, in_ready=1 and new data SHALL flow with no stale pixels.
